cond_exec_stage: RTL and testbench

- Execute-stage consumer of the decode-stage control bundle.
- Registers the D-stage control signals into E, holds the architectural NZCV flags register, and evaluates the 4-bit condition field against the current flags.
- Gates every architectural side effect of the E-stage instruction by the condition result: register write, memory write, PC redirect, branch and flag update.
- Sits between the decode-stage control unit and the E/M pipeline register; it is the receiving end of that control interface.

---
 rtl/cond_exec_stage_pkg.sv | 29 ++
 rtl/cond_exec_stage_cond_check.sv | 40 ++++
 rtl/cond_exec_stage.sv | 114 +++++++++++
 tb/tb_cond_exec_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_exec_stage_pkg.sv
// Shared constants for the execute-stage condition logic: condition codes,
// NZCV bit positions and the default ALU control width.
package cond_exec_stage_pkg;

  localparam int ALUCTRL_W_DEF = 5;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Condition table: decides whether an instruction with condition field Cond
// executes, given the architectural NZCV flags.
module cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute stage: registers the decode control bundle, owns the NZCV register
// and gates every architectural side effect by the instruction's condition.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter int         ALUCTRL_W = ALUCTRL_W_DEF,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushE,
  input  logic                 StallE,
  input  logic [3:0]           CondD,
  input  logic                 PCSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemtoRegD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 NoWriteD,
  input  logic                 IgRnD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [1:0]           FlagWriteD,
  input  logic [3:0]           ALUFlags,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 MemtoRegE,
  output logic                 IgRnE,
  output logic                 PCSrcE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 BranchTakenE,
  output logic                 CondExE,
  output logic [3:0]           FlagsE
);

  logic       pcSrcReg;
  logic       regWriteReg;
  logic       memWriteReg;
  logic       branchReg;
  logic       noWriteReg;
  logic [1:0] flagWriteReg;
  logic [3:0] condReg;
  logic [3:0] flagsReg;

  cond_check uCondCheck (
    .Cond   (condReg),
    .Flags  (flagsReg),
    .CondEx (CondExE)
  );

  // Flag write belongs to the instruction already in E, so a flush (which only
  // replaces the incoming D->E load) does not suppress it; a stall does.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcSrcReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      memWriteReg  <= 1'b0;
      branchReg    <= 1'b0;
      noWriteReg   <= 1'b0;
      flagWriteReg <= 2'b00;
      condReg      <= COND_AL;
      ALUControlE  <= '0;
      ALUSrcE      <= 1'b0;
      MemtoRegE    <= 1'b0;
      IgRnE        <= 1'b0;
      flagsReg     <= FLAGS_RST;
    end else begin
      if (!StallE) begin
        if (flagWriteReg[1] && CondExE) begin
          flagsReg[FLAG_N] <= ALUFlags[FLAG_N];
          flagsReg[FLAG_Z] <= ALUFlags[FLAG_Z];
        end
        if (flagWriteReg[0] && CondExE) begin
          flagsReg[FLAG_C] <= ALUFlags[FLAG_C];
          flagsReg[FLAG_V] <= ALUFlags[FLAG_V];
        end
      end
      if (FlushE) begin
        pcSrcReg     <= 1'b0;
        regWriteReg  <= 1'b0;
        memWriteReg  <= 1'b0;
        branchReg    <= 1'b0;
        noWriteReg   <= 1'b0;
        flagWriteReg <= 2'b00;
        condReg      <= COND_AL;
        ALUControlE  <= '0;
        ALUSrcE      <= 1'b0;
        MemtoRegE    <= 1'b0;
        IgRnE        <= 1'b0;
      end else if (!StallE) begin
        pcSrcReg     <= PCSrcD;
        regWriteReg  <= RegWriteD;
        memWriteReg  <= MemWriteD;
        branchReg    <= BranchD;
        noWriteReg   <= NoWriteD;
        flagWriteReg <= FlagWriteD;
        condReg      <= CondD;
        ALUControlE  <= ALUControlD;
        ALUSrcE      <= ALUSrcD;
        MemtoRegE    <= MemtoRegD;
        IgRnE        <= IgRnD;
      end
    end
  end

  // Compare-class instructions never write a register, whatever the condition.
  assign PCSrcE       = pcSrcReg & CondExE;
  assign RegWriteE    = regWriteReg & CondExE & ~noWriteReg;
  assign MemWriteE    = memWriteReg & CondExE;
  assign BranchTakenE = branchReg & CondExE;
  assign FlagsE       = flagsReg;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: condition-table vectors, hand-written pipeline
// sequences and randomized traffic checked against a behavioural model.
module tb_cond_exec_stage;

  typedef struct packed {
    logic [3:0] cond;
    logic       pcSrc;
    logic       regWrite;
    logic       memtoReg;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic       noWrite;
    logic       igRn;
    logic [4:0] aluCtrl;
    logic [1:0] flagWrite;
  } dCtl_t;

  typedef struct {
    logic [3:0]  flagsPat;
    logic [15:0] expMask;
  } sweepVec_t;

  logic       clk = 1'b0;
  logic       reset, flushE, stallE;
  logic [3:0] aluFlags;
  dCtl_t      dIn;

  logic [4:0] ALUControlE;
  logic       ALUSrcE, MemtoRegE, IgRnE, PCSrcE, RegWriteE, MemWriteE;
  logic       BranchTakenE, CondExE;
  logic [3:0] FlagsE;

  int vecCount = 0;
  int errCount = 0;
  logic [16:0] expQ[$];

  dCtl_t      mE;
  logic [3:0] mFlags;

  cond_exec_stage dut (
    .clk          (clk),
    .reset        (reset),
    .FlushE       (flushE),
    .StallE       (stallE),
    .CondD        (dIn.cond),
    .PCSrcD       (dIn.pcSrc),
    .RegWriteD    (dIn.regWrite),
    .MemtoRegD    (dIn.memtoReg),
    .MemWriteD    (dIn.memWrite),
    .BranchD      (dIn.branch),
    .ALUSrcD      (dIn.aluSrc),
    .NoWriteD     (dIn.noWrite),
    .IgRnD        (dIn.igRn),
    .ALUControlD  (dIn.aluCtrl),
    .FlagWriteD   (dIn.flagWrite),
    .ALUFlags     (aluFlags),
    .ALUControlE  (ALUControlE),
    .ALUSrcE      (ALUSrcE),
    .MemtoRegE    (MemtoRegE),
    .IgRnE        (IgRnE),
    .PCSrcE       (PCSrcE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .BranchTakenE (BranchTakenE),
    .CondExE      (CondExE),
    .FlagsE       (FlagsE)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the E slot holds the last accepted D record, flags are a
  // plain 4-bit value updated from the spec's condition rules.
  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] expOut(input dCtl_t e, input logic [3:0] f);
    logic ce;
    ce = condHolds(e.cond, f);
    return {e.aluCtrl, e.aluSrc, e.memtoReg, e.igRn, e.pcSrc & ce,
            e.regWrite & ce & !e.noWrite, e.memWrite & ce, e.branch & ce, ce, f};
  endfunction

  task automatic modelEdge();
    logic ce;
    if (reset) begin
      mE = '0;
      mE.cond = 4'b1110;
      mFlags = 4'b0000;
    end else begin
      ce = condHolds(mE.cond, mFlags);
      if (!stallE) begin
        if (mE.flagWrite[1] && ce) mFlags[3:2] = aluFlags[3:2];
        if (mE.flagWrite[0] && ce) mFlags[1:0] = aluFlags[1:0];
      end
      if (flushE) begin
        mE = '0;
        mE.cond = 4'b1110;
      end else if (!stallE) begin
        mE = dIn;
      end
    end
  endtask

  // Driver: one clock edge, model update, scoreboard compare #1 after the edge
  task automatic cycle();
    logic [16:0] exp;
    logic [16:0] act;
    @(posedge clk);
    modelEdge();
    expQ.push_back(expOut(mE, mFlags));
    #1;
    exp = expQ.pop_front();
    act = {ALUControlE, ALUSrcE, MemtoRegE, IgRnE, PCSrcE, RegWriteE,
           MemWriteE, BranchTakenE, CondExE, FlagsE};
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  function automatic dCtl_t alOp(input logic [1:0] fw);
    dCtl_t d;
    d = '0;
    d.cond = 4'b1110;
    d.flagWrite = fw;
    return d;
  endfunction

  sweepVec_t sweepTab[6];
  logic [31:0] rnd;

  initial begin
    // Expected CondEx per code (bit i = condition code i) for each flag pattern
    sweepTab[0] = '{4'b0000, 16'h56AA};
    sweepTab[1] = '{4'b0100, 16'h66A9};
    sweepTab[2] = '{4'b1000, 16'h6A9A};
    sweepTab[3] = '{4'b0010, 16'h55A6};
    sweepTab[4] = '{4'b0001, 16'h6A6A};
    sweepTab[5] = '{4'b1001, 16'h565A};

    reset = 1'b1; flushE = 1'b0; stallE = 1'b0; aluFlags = 4'b1111;
    dIn = '1;
    cycle();
    cycle();
    check("rst_gated", {12'd0, PCSrcE, RegWriteE, MemWriteE, BranchTakenE}, 16'd0);
    check("rst_flags", {12'd0, FlagsE}, 16'd0);
    reset = 1'b0; dIn = '0; aluFlags = 4'b0000;
    cycle();
    check("rst_release_gated", {12'd0, PCSrcE, RegWriteE, MemWriteE, BranchTakenE}, 16'd0);
    check("rst_release_flags", {12'd0, FlagsE}, 16'd0);

    // Condition sweep
    for (int t = 0; t < 6; t++) begin
      dIn = alOp(2'b11);
      cycle();
      aluFlags = sweepTab[t].flagsPat;
      for (int c = 0; c < 16; c++) begin
        dIn = '0;
        dIn.cond = 4'(c);
        dIn.regWrite = 1'b1;
        cycle();
        check($sformatf("sweep_f%b_c%0d", sweepTab[t].flagsPat, c),
              {15'd0, RegWriteE}, {15'd0, sweepTab[t].expMask[c]});
      end
      check("sweep_flags", {12'd0, FlagsE}, {12'd0, sweepTab[t].flagsPat});
    end

    // Partial flag writes
    dIn = alOp(2'b11);
    cycle();
    aluFlags = 4'b1111; dIn = alOp(2'b10);
    cycle();
    check("partial_preload", {12'd0, FlagsE}, 16'h000F);
    aluFlags = 4'b0000; dIn = alOp(2'b01);
    cycle();
    check("partial_nz", {12'd0, FlagsE}, 16'h0003);
    dIn = alOp(2'b00);
    cycle();
    check("partial_cv", {12'd0, FlagsE}, 16'h0000);

    // CMP then BEQ, taken and not taken
    for (int k = 0; k < 2; k++) begin
      dIn = alOp(2'b11);
      dIn.noWrite = 1'b1;
      dIn.regWrite = 1'b1;
      cycle();
      check("cmp_nowrite", {15'd0, RegWriteE}, 16'd0);
      aluFlags = (k == 0) ? 4'b0100 : 4'b0000;
      dIn = '0;
      dIn.cond = 4'b0000;
      dIn.branch = 1'b1;
      cycle();
      check("beq_taken", {15'd0, BranchTakenE}, (k == 0) ? 16'd1 : 16'd0);
    end

    // Stall holds E and flags; flush beats stall
    aluFlags = 4'b0000;
    dIn = alOp(2'b11);
    dIn.memWrite = 1'b1;
    cycle();
    check("stall_load", {15'd0, MemWriteE}, 16'd1);
    stallE = 1'b1;
    aluFlags = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      rnd = $urandom;
      dIn = rnd[18:0];
      cycle();
      check("stall_memwrite", {15'd0, MemWriteE}, 16'd1);
      check("stall_flags", {12'd0, FlagsE}, 16'd0);
    end
    flushE = 1'b1;
    cycle();
    check("flush_stall", {15'd0, MemWriteE}, 16'd0);
    check("flush_stall_flags", {12'd0, FlagsE}, 16'd0);
    flushE = 1'b0; stallE = 1'b0;

    // Failed condition suppresses every side effect including flags
    aluFlags = 4'b0000;
    dIn = alOp(2'b11);
    dIn.cond = 4'b0000;
    dIn.regWrite = 1'b1;
    dIn.memWrite = 1'b1;
    dIn.pcSrc = 1'b1;
    cycle();
    aluFlags = 4'b1111;
    dIn = alOp(2'b00);
    check("fail_cond_gated", {13'd0, RegWriteE, MemWriteE, PCSrcE}, 16'd0);
    cycle();
    check("fail_cond_flags", {12'd0, FlagsE}, 16'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rnd = $urandom;
      dIn = rnd[18:0];
      aluFlags = 4'($urandom_range(0, 15));
      flushE = ($urandom_range(0, 7) == 0);
      stallE = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0; flushE = 1'b0; stallE = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
